// File: rtl/voter_pkg.sv
// Shared types for the ballot session: FSM states and threshold modes.
package voter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    TALLY = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    MODE_SIMPLE = 2'd0,
    MODE_ABS    = 2'd1,
    MODE_UNAN   = 2'd2,
    MODE_2_3    = 2'd3
  } mode_t;

endpackage

// File: rtl/voter_threshold.sv
// Combinational verdict from final yes/no counts under the selected threshold mode.
module voter_threshold
  import voter_pkg::*;
#(
  parameter int unsigned N_VOTERS = 4,
  parameter int unsigned CW       = $clog2(N_VOTERS + 1)
) (
  input  logic [CW-1:0] yes_cnt,
  input  logic [CW-1:0] no_cnt,
  input  mode_t         mode,
  output logic          pass_next
);

  // Two extra bits hold 3*yes_cnt and 2*N_VOTERS without overflow.
  localparam int unsigned WW = CW + 2;

  logic [WW-1:0] yes_w;
  logic [WW-1:0] n_w;

  assign yes_w = WW'(yes_cnt);
  assign n_w   = WW'(N_VOTERS);

  always_comb begin
    pass_next = 1'b0;
    case (mode)
      MODE_SIMPLE: pass_next = (yes_cnt > no_cnt);
      MODE_ABS:    pass_next = ((yes_w << 1) > n_w);
      MODE_UNAN:   pass_next = (yes_w == n_w);
      MODE_2_3:    pass_next = ((yes_w * WW'(3)) >= (n_w << 1));
      default:     pass_next = 1'b0;
    endcase
  end

endmodule

// File: rtl/voter_session.sv
// One ballot session: open on start, collect one vote per voter, close on
// request/all-voted/timeout, then tally and report a verdict.
module voter_session
  import voter_pkg::*;
#(
  parameter  int unsigned N_VOTERS = 4,
  parameter  int unsigned TIMEOUT  = 16,
  localparam int unsigned CW       = $clog2(N_VOTERS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [N_VOTERS-1:0] vote_en,
  input  logic [N_VOTERS-1:0] vote_val,
  input  logic                close,
  output logic                busy,
  output logic [N_VOTERS-1:0] voted,
  output logic [CW-1:0]       yes_cnt,
  output logic [CW-1:0]       no_cnt,
  output logic                result_valid,
  output logic                pass,
  output logic                timed_out
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  state_t              state;
  mode_t               mode_q;
  logic [TW-1:0]       timer;
  logic [N_VOTERS-1:0] new_votes;
  logic [N_VOTERS-1:0] yes_new;
  logic [N_VOTERS-1:0] no_new;
  logic [CW-1:0]       yes_inc;
  logic [CW-1:0]       no_inc;
  logic                all_voted;
  logic                timer_hit;
  logic                pass_next;

  function automatic logic [CW-1:0] popcnt(input logic [N_VOTERS-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < N_VOTERS; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  // First vote wins: only voters not yet marked count this cycle.
  always_comb begin
    new_votes = vote_en & ~voted;
    yes_new   = new_votes & vote_val;
    no_new    = new_votes & ~vote_val;
    yes_inc   = popcnt(yes_new);
    no_inc    = popcnt(no_new);
    all_voted = &(voted | new_votes);
    timer_hit = (timer == TW'(TIMEOUT - 1));
  end

  voter_threshold #(
    .N_VOTERS (N_VOTERS),
    .CW       (CW)
  ) u_threshold (
    .yes_cnt   (yes_cnt),
    .no_cnt    (no_cnt),
    .mode      (mode_q),
    .pass_next (pass_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mode_q       <= MODE_SIMPLE;
      timer        <= '0;
      busy         <= 1'b0;
      voted        <= '0;
      yes_cnt      <= '0;
      no_cnt       <= '0;
      result_valid <= 1'b0;
      pass         <= 1'b0;
      timed_out    <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= OPEN;
            mode_q    <= mode_t'(mode);
            timer     <= '0;
            busy      <= 1'b1;
            voted     <= '0;
            yes_cnt   <= '0;
            no_cnt    <= '0;
            pass      <= 1'b0;
            timed_out <= 1'b0;
          end
        end
        OPEN: begin
          voted   <= voted | new_votes;
          yes_cnt <= yes_cnt + yes_inc;
          no_cnt  <= no_cnt + no_inc;
          timer   <= timer + TW'(1);
          // Explicit close and all-voted outrank the timeout as exit cause.
          if (close || all_voted || timer_hit) begin
            state     <= TALLY;
            timed_out <= timer_hit && !close && !all_voted;
          end
        end
        TALLY: begin
          state        <= IDLE;
          busy         <= 1'b0;
          pass         <= pass_next;
          result_valid <= 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_voter_session.sv
// Directed bench for voter_session (N_VOTERS=4, TIMEOUT=8): per-cycle vector table plus reset/start-ignore sequences.
module tb_voter_session;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [1:0]    mode;
  logic [N-1:0]  vote_en;
  logic [N-1:0]  vote_val;
  logic          close;
  logic          busy;
  logic [N-1:0]  voted;
  logic [CW-1:0] yes_cnt;
  logic [CW-1:0] no_cnt;
  logic          result_valid;
  logic          pass;
  logic          timed_out;

  voter_session #(.N_VOTERS(N), .TIMEOUT(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .vote_en      (vote_en),
    .vote_val     (vote_val),
    .close        (close),
    .busy         (busy),
    .voted        (voted),
    .yes_cnt      (yes_cnt),
    .no_cnt       (no_cnt),
    .result_valid (result_valid),
    .pass         (pass),
    .timed_out    (timed_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic [1:0]    md;
    logic [N-1:0]  en;
    logic [N-1:0]  val;
    logic          cl;
    logic          e_busy;
    logic [N-1:0]  e_voted;
    logic [CW-1:0] e_yes;
    logic [CW-1:0] e_no;
    logic          e_rv;
    logic          e_pass;
    logic          e_to;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
  endtask

  task automatic r(input logic st, input logic [1:0] md, input logic [N-1:0] en, input logic [N-1:0] val,
                   input logic cl, input logic bz, input logic [N-1:0] vt, input int y, input int n,
                   input logic rv, input logic ps, input logic tmo);
    vec_t v;
    v.st = st; v.md = md; v.en = en; v.val = val; v.cl = cl;
    v.e_busy = bz; v.e_voted = vt; v.e_yes = CW'(y); v.e_no = CW'(n);
    v.e_rv = rv; v.e_pass = ps; v.e_to = tmo;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic st, input logic [1:0] md, input logic [N-1:0] en,
                       input logic [N-1:0] val, input logic cl);
    @(negedge clk);
    start = st; mode = md; vote_en = en; vote_val = val; close = cl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input int row, input logic bz, input logic [N-1:0] vt, input logic [CW-1:0] y,
                           input logic [CW-1:0] n, input logic rv, input logic ps, input logic tmo);
    chk("busy", row, 32'(busy), 32'(bz));
    chk("voted", row, 32'(voted), 32'(vt));
    chk("yes_cnt", row, 32'(yes_cnt), 32'(y));
    chk("no_cnt", row, 32'(no_cnt), 32'(n));
    chk("result_valid", row, 32'(result_valid), 32'(rv));
    chk("pass", row, 32'(pass), 32'(ps));
    chk("timed_out", row, 32'(timed_out), 32'(tmo));
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0; start = 1'b0; mode = 2'd0; vote_en = '0; vote_val = '0; close = 1'b0;
    #12;
    check_all(-1, 0, 4'b0000, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_all(-2, 0, 4'b0000, 0, 0, 0, 0, 0);

    // Session A: mode 0, three separate votes then close.
    r(1,0,4'b0000,4'b0000,0, 1,4'b0000,0,0,0,0,0);
    r(0,0,4'b0001,4'b0001,0, 1,4'b0001,1,0,0,0,0);
    r(0,0,4'b0010,4'b0010,0, 1,4'b0011,2,0,0,0,0);
    r(0,0,4'b0100,4'b0000,0, 1,4'b0111,2,1,0,0,0);
    r(0,0,4'b0000,4'b0000,1, 1,4'b0111,2,1,0,0,0);
    r(0,0,4'b0000,4'b0000,0, 0,4'b0111,2,1,1,1,0);
    r(0,0,4'b0000,4'b0000,0, 0,4'b0111,2,1,0,1,0);
    // Session B: repeat vote from voter 0 ignored.
    r(1,0,4'b0000,4'b0000,0, 1,4'b0000,0,0,0,0,0);
    r(0,0,4'b0001,4'b0001,0, 1,4'b0001,1,0,0,0,0);
    r(0,0,4'b0001,4'b0000,0, 1,4'b0001,1,0,0,0,0);
    r(0,0,4'b0000,4'b0000,1, 1,4'b0001,1,0,0,0,0);
    r(0,0,4'b0000,4'b0000,0, 0,4'b0001,1,0,1,1,0);
    // Session C: start on the result_valid cycle; all vote at once, unanimous fails.
    r(1,2,4'b0000,4'b0000,0, 1,4'b0000,0,0,0,0,0);
    r(0,2,4'b1111,4'b0111,0, 1,4'b1111,3,1,0,0,0);
    r(0,0,4'b0000,4'b0000,0, 0,4'b1111,3,1,1,0,0);
    // Session D: mode 1, timeout after 8 OPEN cycles.
    r(1,1,4'b0000,4'b0000,0, 1,4'b0000,0,0,0,0,0);
    r(0,1,4'b0001,4'b0001,0, 1,4'b0001,1,0,0,0,0);
    r(0,1,4'b0010,4'b0010,0, 1,4'b0011,2,0,0,0,0);
    for (int i = 0; i < 5; i++) r(0,1,4'b0000,4'b0000,0, 1,4'b0011,2,0,0,0,0);
    r(0,1,4'b0000,4'b0000,0, 1,4'b0011,2,0,0,0,1);
    r(0,1,4'b0000,4'b0000,0, 0,4'b0011,2,0,1,0,1);
    r(0,1,4'b0000,4'b0000,1, 0,4'b0011,2,0,0,0,1);
    // Session E: mode 3, close coincides with the timeout cycle.
    r(1,3,4'b0000,4'b0000,0, 1,4'b0000,0,0,0,0,0);
    r(0,3,4'b0001,4'b0001,0, 1,4'b0001,1,0,0,0,0);
    r(0,3,4'b0010,4'b0010,0, 1,4'b0011,2,0,0,0,0);
    r(0,3,4'b0100,4'b0100,0, 1,4'b0111,3,0,0,0,0);
    for (int i = 0; i < 4; i++) r(0,3,4'b0000,4'b0000,0, 1,4'b0111,3,0,0,0,0);
    r(0,3,4'b0000,4'b0000,1, 1,4'b0111,3,0,0,0,0);
    r(0,3,4'b0000,4'b0000,0, 0,4'b0111,3,0,1,1,0);

    foreach (tbl[i]) begin
      drive(tbl[i].st, tbl[i].md, tbl[i].en, tbl[i].val, tbl[i].cl);
      check_all(i, tbl[i].e_busy, tbl[i].e_voted, tbl[i].e_yes, tbl[i].e_no,
                tbl[i].e_rv, tbl[i].e_pass, tbl[i].e_to);
    end

    // Reset mid-session aborts without a verdict.
    drive(1, 0, 4'b0000, 4'b0000, 0);
    drive(0, 0, 4'b0001, 4'b0001, 0);
    drive(0, 0, 4'b0010, 4'b0000, 0);
    check_all(100, 1, 4'b0011, 1, 1, 0, 0, 0);
    @(negedge clk);
    vote_en = '0; rst_n = 1'b0;
    #1;
    check_all(101, 0, 4'b0000, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1'b1;
    end
    chk("no_rv_after_reset", 102, 32'(seen), 32'(0));
    chk("idle_after_reset", 103, 32'(busy), 32'(0));

    // Start during OPEN is ignored.
    drive(1, 0, 4'b0000, 4'b0000, 0);
    drive(0, 0, 4'b0100, 4'b0100, 0);
    drive(1, 2, 4'b0000, 4'b0000, 0);
    check_all(104, 1, 4'b0100, 1, 0, 0, 0, 0);
    drive(0, 0, 4'b0000, 4'b0000, 1);
    seen = 1'b0;
    for (int i = 0; i < 5 && !seen; i++) begin
      drive(0, 0, 4'b0000, 4'b0000, 0);
      if (result_valid) seen = 1'b1;
    end
    chk("rv_after_close", 105, 32'(seen), 32'(1));
    // Mode 0 still in effect: 1 yes vs 0 no passes.
    chk("pass_mode_kept", 106, 32'(pass), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/voter_session.md
Name: voter_session

Overview:
- Sequential, parametrised successor to the combinational 4-input voter.
- Runs one ballot session across N_VOTERS voters, in strict order:
  - opens on `start`;
  - accepts at most one vote per voter;
  - closes on an explicit `close`, on all voters having voted, or on timeout;
  - tallies, then reports yes/no counts and a pass/fail verdict under a selectable threshold mode.
- Sits between the voter input front-end and the decision/display logic.

Parameters:
- N_VOTERS, 4, number of voters (2..32).
- TIMEOUT, 16, maximum OPEN-state cycles before forced close (>=2).
- CW, $clog2(N_VOTERS+1), count width (derived, localparam).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; opens a session when IDLE.
- mode  in  2  threshold mode, sampled on accepted `start`.
- vote_en  in  N_VOTERS  per-voter vote strobe.
- vote_val  in  N_VOTERS  per-voter vote value (1 = yes, 0 = no), qualified by `vote_en`.
- close  in  1  early-close request.
- busy  out  1  session in progress (state != IDLE).
- voted  out  N_VOTERS  voter i has cast its vote this session.
- yes_cnt  out  CW  yes votes counted.
- no_cnt  out  CW  no votes counted.
- result_valid  out  1  one-cycle pulse when the verdict is ready.
- pass  out  1  verdict, held until the next accepted `start`.
- timed_out  out  1  session closed by timeout; held until the next accepted `start`.

Behaviour:
- Reset:
  - asynchronous; state = IDLE.
  - All outputs 0: `busy`, `voted`, `yes_cnt`, `no_cnt`, `result_valid`, `pass`, `timed_out`.
  - Internal mode register and timer = 0.
  - `rst_n` asserted mid-session aborts it immediately; no `result_valid` is produced.
- States: IDLE -> OPEN -> TALLY -> IDLE.
- IDLE:
  - `start` = 1 latches `mode`.
  - Clears `voted`, counts, timer, `pass` and `timed_out`.
  - Next state OPEN.
- OPEN:
  - Each cycle, every voter i with `vote_en[i]` & ~`voted[i]` sets `voted[i]` and increments `yes_cnt` (`vote_val[i]` = 1) or `no_cnt` (`vote_val[i]` = 0).
  - Multiple voters in one cycle are all counted; count increments are popcounts, never saturating (max N_VOTERS fits CW).
  - A repeat `vote_en` from a voter that has already voted is ignored (first vote wins).
  - Timer increments every OPEN cycle.
  - Exit to TALLY when any of the following holds this cycle:
    - `close` = 1;
    - all voters have voted, including this cycle's votes;
    - timer == TIMEOUT-1.
  - Votes presented in the exit cycle are counted.
  - `timed_out` is set only if the timeout condition is the sole exit cause; `close` or all-voted takes priority.
- TALLY (one cycle):
  - Registers `pass` from the final counts.
  - Registers `result_valid` = 1, so the pulse is visible in the following (IDLE) cycle.
- Latency: exit-condition cycle T, TALLY at T+1, `result_valid`/`pass` visible at T+2.
- Mode rules (widen before multiply; no overflow):
  - 0 simple majority: yes_cnt > no_cnt (tie fails).
  - 1 absolute majority: 2*yes_cnt > N_VOTERS.
  - 2 unanimous: yes_cnt == N_VOTERS.
  - 3 two-thirds: 3*yes_cnt >= 2*N_VOTERS.
- `start` outside IDLE is ignored; `close` outside OPEN is ignored.
- `start` on the IDLE cycle carrying the `result_valid` pulse is accepted; the next session begins and `pass` is cleared on the following edge.
- Counts, `voted` and `timed_out` stay stable in IDLE until the next accepted `start`.

Decomposition:
- Package voter_pkg:
  - state_t enum (IDLE, OPEN, TALLY);
  - mode_t enum (MODE_SIMPLE=0, MODE_ABS=1, MODE_UNAN=2, MODE_2_3=3).
- Sub-module voter_threshold (combinational): inputs yes_cnt, no_cnt, mode; output pass_next; parametrised by N_VOTERS and CW.
- Popcount stays inside voter_session.

Test Plan (N_VOTERS=4, TIMEOUT=8):
- start mode=0; vote voters 0,1 yes and voter 2 no in separate cycles; close -> yes_cnt=2, no_cnt=1, voted=4'b0111, result_valid pulse 2 cycles after close, pass=1, timed_out=0.
- start mode=0; voter 0 yes; voter 0 later with vote_val=0; close -> yes_cnt=1, no_cnt=0 (repeat ignored), pass=1.
- start mode=2; vote_en=4'b1111 with vote_val=4'b0111 in one cycle -> auto-close, yes_cnt=3, no_cnt=1, pass=0, timed_out=0.
- start mode=1; voters 0,1 yes; no close -> forced close after 8 OPEN cycles, timed_out=1, yes_cnt=2, pass=0 (4 > 4 false).
- start mode=3; voters 0,1,2 yes; close asserted in the same cycle as timer==7 -> yes_cnt=3, pass=1 (9 >= 8), timed_out=0 (close wins).
- start, 2 votes; rst_n low mid-OPEN -> busy=0, voted=0, counts=0, no result_valid. New session: start during OPEN is ignored (counts unchanged, busy stays 1).
